exec_cond_stage: RTL and testbench

Conditional-execute and result-buffer stage directly downstream of the 32-bit ALU. It accepts one ALU result per handshake together with its 4-bit ALU flags and the instruction's control bits. It evaluates the ARM condition field against the architectural NZCV register, squashes writes for failed conditions, and updates NZCV per the flag-write mask. Accepted results go into a 2-entry buffer that drives the writeback/memory stage through a valid/ready handshake.

---
 rtl/exec_cond_stage.sv | 149 ++++++++++++++
 tb/tb_exec_cond_stage.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/exec_cond_stage.sv
// Conditional-execute stage after the ALU: checks the cond field against NZCV, squashes failed ops, buffers 2 results.
// Latency: an accepted entry is visible on out_* the cycle after the accepting edge when the buffer was empty.
// Backpressure: in_ready = (count < 2) from registered state only; out_ready never reaches in_ready combinationally.
module exec_cond_stage #(
  parameter int SQ_W = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_result,
  input  logic [3:0]      in_flags,
  input  logic [3:0]      in_cond,
  input  logic [1:0]      in_flag_w,
  input  logic            in_reg_write,
  input  logic            in_mem_write,
  input  logic            in_pc_src,
  input  logic [3:0]      in_rd,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [31:0]     out_result,
  output logic [3:0]      out_rd,
  output logic            out_reg_write,
  output logic            out_mem_write,
  output logic            out_pc_src,
  output logic            out_cond_ex,
  output logic [3:0]      nzcv,
  output logic [SQ_W-1:0] squash_cnt
);

  typedef struct packed {
    logic [31:0] result;
    logic [3:0]  rd;
    logic        reg_write;
    logic        mem_write;
    logic        pc_src;
    logic        cond_ex;
  } entry_t;

  entry_t          head_q, head_d, tail_q, tail_d, new_ent;
  logic [1:0]      cnt_q, cnt_d;
  logic [3:0]      nzcv_q, nzcv_d;
  logic [SQ_W-1:0] sq_q, sq_d;
  logic            cond_pass, push, pop;
  logic            f_n, f_z, f_c, f_v;

  assign in_ready  = (cnt_q < 2'd2);
  assign out_valid = (cnt_q != 2'd0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  // Condition is judged only against the registered flags, never the incoming ones.
  assign {f_n, f_z, f_c, f_v} = nzcv_q;

  always_comb begin
    cond_pass = 1'b1;
    case (in_cond)
      4'b0000: cond_pass = f_z;
      4'b0001: cond_pass = !f_z;
      4'b0010: cond_pass = f_c;
      4'b0011: cond_pass = !f_c;
      4'b0100: cond_pass = f_n;
      4'b0101: cond_pass = !f_n;
      4'b0110: cond_pass = f_v;
      4'b0111: cond_pass = !f_v;
      4'b1000: cond_pass = f_c && !f_z;
      4'b1001: cond_pass = !f_c || f_z;
      4'b1010: cond_pass = (f_n == f_v);
      4'b1011: cond_pass = (f_n != f_v);
      4'b1100: cond_pass = !f_z && (f_n == f_v);
      4'b1101: cond_pass = f_z || (f_n != f_v);
      default: cond_pass = 1'b1;
    endcase
  end

  always_comb begin
    new_ent.result    = in_result;
    new_ent.rd        = in_rd;
    new_ent.reg_write = in_reg_write && cond_pass;
    new_ent.mem_write = in_mem_write && cond_pass;
    new_ent.pc_src    = in_pc_src && cond_pass;
    new_ent.cond_ex   = cond_pass;
  end

  always_comb begin
    head_d = head_q;
    tail_d = tail_q;
    cnt_d  = cnt_q;
    nzcv_d = nzcv_q;
    sq_d   = sq_q;

    case ({push, pop})
      2'b10: begin
        if (cnt_q == 2'd0) head_d = new_ent;
        else               tail_d = new_ent;
        cnt_d = cnt_q + 2'd1;
      end
      2'b01: begin
        head_d = tail_q;
        cnt_d  = cnt_q - 2'd1;
      end
      2'b11: begin
        // Count stays put; the new entry lands behind whatever survives the pop.
        if (cnt_q == 2'd1) begin
          head_d = new_ent;
        end else begin
          head_d = tail_q;
          tail_d = new_ent;
        end
      end
      default: ;
    endcase

    if (push) begin
      if (cond_pass) begin
        if (in_flag_w[1]) nzcv_d[3:2] = in_flags[3:2];
        if (in_flag_w[0]) nzcv_d[1:0] = in_flags[1:0];
      end else if (sq_q != {SQ_W{1'b1}}) begin
        sq_d = sq_q + SQ_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q <= '0;
      tail_q <= '0;
      cnt_q  <= 2'd0;
      nzcv_q <= 4'b0000;
      sq_q   <= '0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      cnt_q  <= cnt_d;
      nzcv_q <= nzcv_d;
      sq_q   <= sq_d;
    end
  end

  assign out_result    = head_q.result;
  assign out_rd        = head_q.rd;
  assign out_reg_write = head_q.reg_write;
  assign out_mem_write = head_q.mem_write;
  assign out_pc_src    = head_q.pc_src;
  assign out_cond_ex   = head_q.cond_ex;
  assign nzcv          = nzcv_q;
  assign squash_cnt    = sq_q;

endmodule

// File: tb/tb_exec_cond_stage.sv
// Bench for exec_cond_stage: directed scenarios plus random traffic against a queue-based reference model.
module tb_exec_cond_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready, in_reg_write, in_mem_write, in_pc_src;
  logic [31:0] in_result;
  logic [3:0]  in_flags, in_cond, in_rd;
  logic [1:0]  in_flag_w;
  logic        out_valid, out_ready, out_reg_write, out_mem_write, out_pc_src, out_cond_ex;
  logic [31:0] out_result;
  logic [3:0]  out_rd, nzcv;
  logic [15:0] squash_cnt;

  logic        o2_in_ready, o2_out_valid, o2_rw, o2_mw, o2_pc, o2_ce;
  logic [31:0] o2_result;
  logic [3:0]  o2_rd, o2_nzcv;
  logic [1:0]  o2_squash;

  always #5 clk = ~clk;

  exec_cond_stage #(.SQ_W(16)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_result(in_result), .in_flags(in_flags),
    .in_cond(in_cond), .in_flag_w(in_flag_w), .in_reg_write(in_reg_write),
    .in_mem_write(in_mem_write), .in_pc_src(in_pc_src), .in_rd(in_rd),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result), .out_rd(out_rd),
    .out_reg_write(out_reg_write), .out_mem_write(out_mem_write), .out_pc_src(out_pc_src),
    .out_cond_ex(out_cond_ex), .nzcv(nzcv), .squash_cnt(squash_cnt)
  );

  // Same traffic into a narrow-counter copy to observe squash saturation.
  exec_cond_stage #(.SQ_W(2)) u_dut_sq2 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(o2_in_ready), .in_result(in_result), .in_flags(in_flags),
    .in_cond(in_cond), .in_flag_w(in_flag_w), .in_reg_write(in_reg_write),
    .in_mem_write(in_mem_write), .in_pc_src(in_pc_src), .in_rd(in_rd),
    .out_valid(o2_out_valid), .out_ready(out_ready), .out_result(o2_result), .out_rd(o2_rd),
    .out_reg_write(o2_rw), .out_mem_write(o2_mw), .out_pc_src(o2_pc),
    .out_cond_ex(o2_ce), .nzcv(o2_nzcv), .squash_cnt(o2_squash)
  );

  typedef struct {
    logic [31:0] res;
    logic [3:0]  rd;
    logic        rw, mw, pc, ce;
  } ent_t;

  ent_t       mq[$];
  logic [3:0] m_nzcv;
  int         m_sq;
  int         checks = 0;
  int         errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit cond_ok(input logic [3:0] c, input logic [3:0] f);
    bit n, z, cy, v;
    n = f[3]; z = f[2]; cy = f[1]; v = f[0];
    case (c)
      4'd0:  return z;
      4'd1:  return !z;
      4'd2:  return cy;
      4'd3:  return !cy;
      4'd4:  return n;
      4'd5:  return !n;
      4'd6:  return v;
      4'd7:  return !v;
      4'd8:  return cy && !z;
      4'd9:  return !cy || z;
      4'd10: return n == v;
      4'd11: return n != v;
      4'd12: return !z && (n == v);
      4'd13: return z || (n != v);
      default: return 1'b1;
    endcase
  endfunction

  task automatic model_edge();
    bit   can_push, can_pop, ok;
    ent_t e;
    can_push = in_valid && (mq.size() < 2);
    can_pop  = (mq.size() != 0) && out_ready;
    if (can_pop) void'(mq.pop_front());
    if (can_push) begin
      ok    = cond_ok(in_cond, m_nzcv);
      e.res = in_result;
      e.rd  = in_rd;
      e.rw  = in_reg_write && ok;
      e.mw  = in_mem_write && ok;
      e.pc  = in_pc_src && ok;
      e.ce  = ok;
      mq.push_back(e);
      if (ok) begin
        if (in_flag_w[1]) m_nzcv[3:2] = in_flags[3:2];
        if (in_flag_w[0]) m_nzcv[1:0] = in_flags[1:0];
      end else begin
        m_sq++;
      end
    end
  endtask

  task automatic check_all();
    check("out_valid", out_valid, mq.size() != 0);
    check("in_ready", in_ready, mq.size() < 2);
    check("nzcv", nzcv, m_nzcv);
    check("squash_cnt", squash_cnt, (m_sq > 65535) ? 65535 : m_sq);
    check("squash_sat2", o2_squash, (m_sq > 3) ? 3 : m_sq);
    if (mq.size() != 0) begin
      check("out_result", out_result, mq[0].res);
      check("out_rd", out_rd, mq[0].rd);
      check("out_reg_write", out_reg_write, mq[0].rw);
      check("out_mem_write", out_mem_write, mq[0].mw);
      check("out_pc_src", out_pc_src, mq[0].pc);
      check("out_cond_ex", out_cond_ex, mq[0].ce);
    end
  endtask

  task automatic step();
    @(posedge clk);
    if (rst_n) model_edge();
    #1;
    check_all();
  endtask

  task automatic drive(input logic v, input logic [31:0] res, input logic [3:0] flags,
                       input logic [3:0] cond, input logic [1:0] fw, input logic rw,
                       input logic mw, input logic pc, input logic [3:0] rd);
    in_valid = v; in_result = res; in_flags = flags; in_cond = cond; in_flag_w = fw;
    in_reg_write = rw; in_mem_write = mw; in_pc_src = pc; in_rd = rd;
  endtask

  task automatic rand_inputs();
    drive($urandom_range(0, 1), $urandom, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
          2'($urandom_range(0, 3)), $urandom_range(0, 1), $urandom_range(0, 1),
          $urandom_range(0, 1), 4'($urandom_range(0, 15)));
  endtask

  initial begin
    rst_n = 1'b0; out_ready = 1'b1; m_nzcv = 4'b0000; m_sq = 0;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);

    // Reset held with random inputs.
    for (int i = 0; i < 4; i++) begin
      rand_inputs();
      out_ready = 1'($urandom_range(0, 1));
      step();
      check("rst_out_result", out_result, 32'd0);
      check("rst_out_enables", {out_reg_write, out_mem_write, out_pc_src, out_cond_ex, out_rd}, 32'd0);
    end

    rst_n = 1'b1; out_ready = 1'b1;
    drive(1, 32'd5, 4'b0000, 4'b1110, 2'b00, 1, 0, 0, 4'd3);
    step();
    check("first_result", out_result, 32'd5);
    check("first_rw", out_reg_write, 1'b1);
    check("first_ce", out_cond_ex, 1'b1);

    // CMP setting Z, then EQ branch (taken) and NE branch (squashed).
    drive(1, 32'd0, 4'b0100, 4'b1110, 2'b11, 0, 0, 0, 4'd0);
    step();
    check("cmp_nzcv", nzcv, 4'b0100);
    drive(1, 32'h100, 4'b1111, 4'b0000, 2'b00, 0, 0, 1, 4'd15);
    step();
    check("eq_pc_src", out_pc_src, 1'b1);
    check("eq_cond_ex", out_cond_ex, 1'b1);
    drive(1, 32'h200, 4'b1011, 4'b0001, 2'b11, 0, 0, 1, 4'd15);
    step();
    check("ne_pc_src", out_pc_src, 1'b0);
    check("ne_cond_ex", out_cond_ex, 1'b0);
    check("ne_squash", squash_cnt, 16'd1);
    check("ne_nzcv", nzcv, 4'b0100);

    // Partial flag-write masks.
    drive(1, 32'd7, 4'b1111, 4'b1110, 2'b11, 0, 0, 0, 4'd1);
    step();
    check("mask_all", nzcv, 4'b1111);
    drive(1, 32'd8, 4'b0000, 4'b1110, 2'b10, 0, 0, 0, 4'd1);
    step();
    check("mask_nz", nzcv, 4'b0011);
    drive(1, 32'd9, 4'b0000, 4'b1110, 2'b01, 0, 0, 0, 4'd1);
    step();
    check("mask_cv", nzcv, 4'b0000);
    drive(0, 0, 0, 4'b1110, 0, 0, 0, 0, 0);
    step();

    // Backpressure with results 1,2,3.
    out_ready = 1'b0;
    drive(1, 32'd1, 0, 4'b1110, 0, 1, 0, 0, 4'd1);
    step();
    drive(1, 32'd2, 0, 4'b1110, 0, 1, 0, 0, 4'd2);
    step();
    check("bp_full_ready", in_ready, 1'b0);
    drive(1, 32'd3, 0, 4'b1110, 0, 1, 0, 0, 4'd3);
    step();
    step();
    check("bp_head", out_result, 32'd1);
    out_ready = 1'b1;
    step();
    check("bp_pop1", out_result, 32'd2);
    check("bp_ready_back", in_ready, 1'b1);
    step();
    check("bp_pop2", out_result, 32'd3);
    drive(0, 0, 0, 4'b1110, 0, 0, 0, 0, 0);
    step();
    check("bp_drained", out_valid, 1'b0);

    // Random valid/ready traffic.
    for (int i = 0; i < 1000; i++) begin
      rand_inputs();
      out_ready = 1'($urandom_range(0, 1));
      step();
    end

    // Fill the buffer with nzcv=1010, then pulse reset between edges.
    out_ready = 1'b0;
    drive(0, 0, 0, 4'b1110, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) step();
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) step();
    out_ready = 1'b0;
    drive(1, 32'hAA, 4'b1010, 4'b1110, 2'b11, 1, 1, 0, 4'd5);
    step();
    step();
    check("pre_rst_nzcv", nzcv, 4'b1010);
    check("pre_rst_full", in_ready, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    check("async_out_valid", out_valid, 1'b0);
    check("async_nzcv", nzcv, 4'b0000);
    check("async_in_ready", in_ready, 1'b1);
    mq.delete(); m_nzcv = 4'b0000; m_sq = 0;
    drive(0, 0, 0, 4'b1110, 0, 0, 0, 0, 0);
    #1 rst_n = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("no_stale", out_valid, 1'b0);
    end

    // Five failed EQ conditions (Z=0): narrow counter saturates at 3.
    for (int i = 0; i < 5; i++) begin
      drive(1, 32'(i), 0, 4'b0000, 2'b11, 1, 1, 1, 4'd2);
      step();
    end
    drive(0, 0, 0, 4'b1110, 0, 0, 0, 0, 0);
    step();
    check("sq2_saturated", o2_squash, 2'd3);
    check("sq16_count", squash_cnt, 16'd5);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
